// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Multiplexed 7-segment display driver. A binary value is captured on
//   load, converted to decimal (sequential double-dabble) or split into hex
//   nibbles, then committed to a display buffer that is scanned
//   continuously onto the shared segment/anode/dp pins.
//
// Ports
//   mclk      board clock, all state on the rising edge
//   rst       asynchronous active-high reset
//   value     binary value to display (VALUE_W bits)
//   load      capture request, honoured only while idle
//   hex_mode  1 = hex digits, 0 = decimal (sampled with load)
//   blank_lz  1 = blank leading zeros (sampled with load)
//   dp_in     per-digit decimal point, 1 = lit (sampled with load)
//   busy      conversion/commit in progress
//   overflow  last committed value did not fit in NUM_DIGITS digits
//   seg       segments g..a, active low
//   an        digit enables, active low, one-hot-low while scanning
//   dp        decimal point, active low
module seg7_scan_driver #(
    parameter int NUM_DIGITS    = 4,
    parameter int VALUE_W       = 8,
    parameter int REFRESH_DIV_W = 17
) (
    input  logic                  mclk,
    input  logic                  rst,
    input  logic [VALUE_W-1:0]    value,
    input  logic                  load,
    input  logic                  hex_mode,
    input  logic                  blank_lz,
    input  logic [NUM_DIGITS-1:0] dp_in,
    output logic                  busy,
    output logic                  overflow,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  dp
);

    localparam int BCD_DIGITS = (VALUE_W * 3) / 10 + 1;
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int DISP_W     = 4 * NUM_DIGITS;
    localparam int BCD_EXT_W  = (BCD_W > DISP_W) ? BCD_W : DISP_W;
    localparam int VAL_EXT_W  = (VALUE_W > DISP_W) ? VALUE_W : DISP_W;
    localparam int STEP_W     = $clog2(VALUE_W + 1);
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_COMMIT
    } state_t;

    state_t                        state_q;
    logic [VALUE_W-1:0]            val_q;
    logic [BCD_W-1:0]              bcd_q;
    logic [BCD_W-1:0]              bcd_adj;
    logic [BCD_W-1:0]              bcd_d;
    logic [STEP_W-1:0]             step_q;
    logic                          hex_q;
    logic                          blank_req_q;
    logic [NUM_DIGITS-1:0]         dp_req_q;

    // Committed display state
    logic [NUM_DIGITS-1:0][3:0]    dig_q;
    logic [NUM_DIGITS-1:0]         dp_buf_q;
    logic                          blank_q;
    logic                          ovf_q;

    logic [NUM_DIGITS-1:0][3:0]    commit_dig;
    logic                          commit_ovf;
    logic [BCD_EXT_W-1:0]          bcd_ext;
    logic [VAL_EXT_W-1:0]          val_ext;

    // Scan state
    logic [REFRESH_DIV_W-1:0]      ref_q;
    logic [IDX_W-1:0]              idx_q;
    logic [6:0]                    seg_q, seg_d;
    logic [NUM_DIGITS-1:0]         an_q, an_d;
    logic                          dp_q, dp_d;
    logic [NUM_DIGITS-1:0]         lz;
    logic                          zero_above;
    logic                          blank_cur;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0:    glyph = 7'h40;
            4'h1:    glyph = 7'h79;
            4'h2:    glyph = 7'h24;
            4'h3:    glyph = 7'h30;
            4'h4:    glyph = 7'h19;
            4'h5:    glyph = 7'h12;
            4'h6:    glyph = 7'h02;
            4'h7:    glyph = 7'h78;
            4'h8:    glyph = 7'h00;
            4'h9:    glyph = 7'h10;
            4'hA:    glyph = 7'h08;
            4'hB:    glyph = 7'h03;
            4'hC:    glyph = 7'h46;
            4'hD:    glyph = 7'h21;
            4'hE:    glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase
    endfunction

    // One double-dabble step: add 3 to every BCD digit >= 5, then shift in
    // the value MSB.
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned d = 0; d < BCD_DIGITS; d++) begin
            if (bcd_q[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
            end
        end
        bcd_d = (bcd_adj << 1) | BCD_W'(val_q[VALUE_W-1]);
    end

    // Zero-extended views so digit slices and the overflow check stay in
    // range regardless of how VALUE_W compares with the display width.
    always_comb begin
        bcd_ext    = BCD_EXT_W'(bcd_q);
        val_ext    = VAL_EXT_W'(val_q);
        commit_dig = '0;
        if (hex_q) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                commit_dig[i] = val_ext[4*i +: 4];
            end
            commit_ovf = (val_ext >> DISP_W) != '0;
        end else begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                commit_dig[i] = bcd_ext[4*i +: 4];
            end
            commit_ovf = (bcd_ext >> DISP_W) != '0;
        end
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            val_q       <= '0;
            bcd_q       <= '0;
            step_q      <= '0;
            hex_q       <= 1'b0;
            blank_req_q <= 1'b0;
            dp_req_q    <= '0;
            dig_q       <= '0;
            dp_buf_q    <= '0;
            blank_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        val_q       <= value;
                        hex_q       <= hex_mode;
                        blank_req_q <= blank_lz;
                        dp_req_q    <= dp_in;
                        bcd_q       <= '0;
                        step_q      <= '0;
                        state_q     <= hex_mode ? ST_COMMIT : ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    bcd_q <= bcd_d;
                    val_q <= val_q << 1;
                    if (step_q == STEP_W'(VALUE_W - 1)) begin
                        state_q <= ST_COMMIT;
                    end else begin
                        step_q <= step_q + 1'b1;
                    end
                end
                ST_COMMIT: begin
                    dig_q    <= commit_dig;
                    dp_buf_q <= dp_req_q;
                    blank_q  <= blank_req_q;
                    ovf_q    <= commit_ovf;
                    state_q  <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // lz[i] is set when digit i and every higher digit are zero.
    always_comb begin
        lz         = '0;
        zero_above = 1'b1;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            zero_above = zero_above && (dig_q[NUM_DIGITS-1-k] == 4'd0);
            lz[NUM_DIGITS-1-k] = zero_above;
        end
    end

    always_comb begin
        blank_cur = blank_q && (idx_q != '0) && !dp_buf_q[idx_q] && lz[idx_q];
        if (ovf_q) begin
            seg_d = SEG_DASH;
            dp_d  = 1'b1;
        end else begin
            seg_d = blank_cur ? SEG_BLANK : glyph(dig_q[idx_q]);
            dp_d  = ~dp_buf_q[idx_q];
        end
        an_d = ~(NUM_DIGITS'(1) << idx_q);
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            ref_q <= '0;
            idx_q <= '0;
            seg_q <= SEG_BLANK;
            an_q  <= '1;
            dp_q  <= 1'b1;
        end else begin
            ref_q <= ref_q + 1'b1;
            // Counter is about to wrap to zero: move to the next digit.
            if (ref_q == '1) begin
                if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                    idx_q <= '0;
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end
            seg_q <= seg_d;
            an_q  <= an_d;
            dp_q  <= dp_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign overflow = ovf_q;
    assign seg      = seg_q;
    assign an       = an_q;
    assign dp       = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

    logic       mclk = 1'b0;
    logic       rst  = 1'b1;

    logic [7:0] value_a = '0;
    logic       load_a = 1'b0, hex_a = 1'b0, blank_a = 1'b0;
    logic [3:0] dpin_a = '0;
    logic       busy_a, ovf_a, dp_a;
    logic [6:0] seg_a;
    logic [3:0] an_a;

    logic [7:0] value_b = '0;
    logic       load_b = 1'b0, hex_b = 1'b0, blank_b = 1'b0;
    logic [1:0] dpin_b = '0;
    logic       busy_b, ovf_b, dp_b;
    logic [6:0] seg_b;
    logic [1:0] an_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 mclk = ~mclk;

    seg7_scan_driver #(.NUM_DIGITS(4), .VALUE_W(8), .REFRESH_DIV_W(2)) dut_a (
        .mclk(mclk), .rst(rst), .value(value_a), .load(load_a),
        .hex_mode(hex_a), .blank_lz(blank_a), .dp_in(dpin_a),
        .busy(busy_a), .overflow(ovf_a), .seg(seg_a), .an(an_a), .dp(dp_a)
    );

    seg7_scan_driver #(.NUM_DIGITS(2), .VALUE_W(8), .REFRESH_DIV_W(2)) dut_b (
        .mclk(mclk), .rst(rst), .value(value_b), .load(load_b),
        .hex_mode(hex_b), .blank_lz(blank_b), .dp_in(dpin_b),
        .busy(busy_b), .overflow(ovf_b), .seg(seg_b), .an(an_b), .dp(dp_b)
    );

    // Passive capture of what each digit position last displayed.
    logic [6:0] rec_seg_a [4];
    logic       rec_dp_a  [4];
    logic [6:0] rec_seg_b [2];
    logic       rec_dp_b  [2];

    always @(negedge mclk) begin
        for (int i = 0; i < 4; i++) begin
            logic [3:0] m;
            m = ~(4'b0001 << i);
            if (an_a === m) begin
                rec_seg_a[i] = seg_a;
                rec_dp_a[i]  = dp_a;
            end
        end
        for (int j = 0; j < 2; j++) begin
            logic [1:0] mb;
            mb = ~(2'b01 << j);
            if (an_b === mb) begin
                rec_seg_b[j] = seg_b;
                rec_dp_b[j]  = dp_b;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge mclk);
    endtask

    // segs = {digit3, digit2, digit1, digit0}; dps = expected active-low dp pins
    task automatic check_digits_a(input string tag, input logic [27:0] segs, input logic [3:0] dps);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s seg%0d", tag, i), {25'd0, rec_seg_a[i]}, {25'd0, segs[7*i +: 7]});
            check($sformatf("%s dp%0d", tag, i), {31'd0, rec_dp_a[i]}, {31'd0, dps[i]});
        end
    endtask

    task automatic load_a_task(input logic [7:0] v, input logic hx, input logic bl, input logic [3:0] d);
        value_a = v; hex_a = hx; blank_a = bl; dpin_a = d; load_a = 1'b1;
        @(negedge mclk);
        load_a = 1'b0;
    endtask

    task automatic load_b_task(input logic [7:0] v, input logic hx, input logic bl, input logic [1:0] d);
        value_b = v; hex_b = hx; blank_b = bl; dpin_b = d; load_b = 1'b1;
        @(negedge mclk);
        load_b = 1'b0;
    endtask

    task automatic count_busy_a(output int n);
        n = 0;
        while (busy_a === 1'b1 && n < 50) begin
            n++;
            @(negedge mclk);
        end
    endtask

    task automatic count_busy_b(output int n);
        n = 0;
        while (busy_b === 1'b1 && n < 50) begin
            n++;
            @(negedge mclk);
        end
    endtask

    initial begin
        int         nb;
        int         rises;
        logic       prev;
        logic [3:0] e;

        // Reset state
        wait_cycles(2);
        check("rst seg_a", {25'd0, seg_a}, 32'h7F);
        check("rst an_a", {28'd0, an_a}, 32'hF);
        check("rst dp_a", {31'd0, dp_a}, 32'h1);
        check("rst busy_a", {31'd0, busy_a}, 32'h0);
        check("rst ovf_a", {31'd0, ovf_a}, 32'h0);
        check("rst an_b", {30'd0, an_b}, 32'h3);
        rst = 1'b0;

        // Scan order: 4 cycles per digit, first enable on the first edge
        for (int k = 1; k <= 17; k++) begin
            @(negedge mclk);
            e = ~(4'b0001 << (((k - 1) / 4) % 4));
            check($sformatf("scan an k=%0d", k), {28'd0, an_a}, {28'd0, e});
        end
        check_digits_a("reset disp", {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF);

        // Decimal 237 with leading-zero blanking
        load_a_task(8'd237, 1'b0, 1'b1, 4'b0000);
        count_busy_a(nb);
        check("dec237 busy cycles", nb, 32'd9);
        wait_cycles(20);
        check("dec237 ovf", {31'd0, ovf_a}, 32'h0);
        check_digits_a("dec237", {7'h7F, 7'h24, 7'h30, 7'h78}, 4'hF);

        // Hex A5, no blanking, dp on digit 1
        load_a_task(8'hA5, 1'b1, 1'b0, 4'b0010);
        count_busy_a(nb);
        check("hexA5 busy cycles", nb, 32'd1);
        wait_cycles(20);
        check("hexA5 ovf", {31'd0, ovf_a}, 32'h0);
        check_digits_a("hexA5", {7'h40, 7'h40, 7'h08, 7'h12}, 4'b1101);

        // Load 100, second load of 7 on the 3rd busy cycle must be ignored
        value_a = 8'd100; hex_a = 1'b0; blank_a = 1'b1; dpin_a = 4'b0000; load_a = 1'b1;
        @(negedge mclk);
        load_a = 1'b0;
        nb = 0;
        while (busy_a === 1'b1 && nb < 50) begin
            nb++;
            if (nb == 3) begin
                value_a = 8'd7;
                load_a  = 1'b1;
            end else begin
                load_a = 1'b0;
            end
            @(negedge mclk);
        end
        load_a = 1'b0;
        check("dec100 busy cycles", nb, 32'd9);
        rises = 0;
        for (int k = 0; k < 20; k++) begin
            prev = busy_a;
            @(negedge mclk);
            if (prev !== 1'b1 && busy_a === 1'b1) rises++;
        end
        check("dec100 no requeue", rises, 32'd0);
        check_digits_a("dec100", {7'h7F, 7'h79, 7'h40, 7'h40}, 4'hF);

        // A zero digit with its dp set is not blanked
        load_a_task(8'd5, 1'b0, 1'b1, 4'b0100);
        count_busy_a(nb);
        check("dec5 busy cycles", nb, 32'd9);
        wait_cycles(20);
        check_digits_a("dec5 dp", {7'h7F, 7'h40, 7'h7F, 7'h12}, 4'b1011);

        // Digit 0 is never blanked
        load_a_task(8'h00, 1'b1, 1'b1, 4'b0000);
        count_busy_a(nb);
        check("hex0 busy cycles", nb, 32'd1);
        wait_cycles(20);
        check_digits_a("hex0 blank", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF);

        // Hex glyphs C and d
        load_a_task(8'hCD, 1'b1, 1'b0, 4'b0000);
        count_busy_a(nb);
        wait_cycles(20);
        check_digits_a("hexCD", {7'h40, 7'h40, 7'h46, 7'h21}, 4'hF);

        // Reset in the middle of a conversion
        load_a_task(8'd99, 1'b0, 1'b0, 4'b0000);
        wait_cycles(2);
        check("mid busy before rst", {31'd0, busy_a}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check("midrst seg", {25'd0, seg_a}, 32'h7F);
        check("midrst an", {28'd0, an_a}, 32'hF);
        check("midrst busy", {31'd0, busy_a}, 32'h0);
        check("midrst dp", {31'd0, dp_a}, 32'h1);
        @(negedge mclk);
        rst = 1'b0;
        wait_cycles(20);
        check("midrst busy after", {31'd0, busy_a}, 32'h0);
        check_digits_a("midrst disp", {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF);

        // Two-digit instance: overflow then recovery
        load_b_task(8'd255, 1'b0, 1'b0, 2'b11);
        count_busy_b(nb);
        check("b255 busy cycles", nb, 32'd9);
        wait_cycles(12);
        check("b255 ovf", {31'd0, ovf_b}, 32'h1);
        check("b255 seg0", {25'd0, rec_seg_b[0]}, 32'h3F);
        check("b255 seg1", {25'd0, rec_seg_b[1]}, 32'h3F);
        check("b255 dp0", {31'd0, rec_dp_b[0]}, 32'h1);
        check("b255 dp1", {31'd0, rec_dp_b[1]}, 32'h1);

        load_b_task(8'd42, 1'b0, 1'b0, 2'b00);
        count_busy_b(nb);
        check("b42 busy cycles", nb, 32'd9);
        wait_cycles(12);
        check("b42 ovf", {31'd0, ovf_b}, 32'h0);
        check("b42 seg0", {25'd0, rec_seg_b[0]}, 32'h24);
        check("b42 seg1", {25'd0, rec_seg_b[1]}, 32'h19);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
